data_mem_responder: RTL

Memory-side responder for the core's load/store port. Accepts one word request (read or byte-enabled write) per handshake and holds it in a word-addressed RAM. Applies a configurable number of wait states, then returns a response over a valid/ready channel. Sits between the core's memory interface (address, write data, read data) and the on-chip data RAM.

---
 rtl/data_mem_responder_pkg.sv | 26 ++
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder_dmem_array.sv | 35 +++
 rtl/data_mem_responder.sv | 96 +++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types, widths and helpers for the data memory responder.
package data_mem_responder_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Captured request payload, held for the whole transaction.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } req_t;

    // Word accesses must sit on a 4-byte boundary; takes the two LSBs of the byte address.
    function automatic logic is_misaligned(input logic [1:0] addr);
        return addr != 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core load/store port: request channel and valid/ready response channel.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [BE_W-1:0] req_be;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port word RAM with per-byte-lane write enables and a registered read port.
module data_mem_responder_dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [BE_W-1:0] be,
    input  logic [AW-1:0]   index,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    localparam int unsigned DEPTH_WORDS = 1 << AW;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Lane-masked write or full-word read; the read register holds between accesses.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[index][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one request, waits WAIT_CYCLES, commits to RAM, responds.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    state_t           state;
    req_t             req_q;
    logic [CNT_W-1:0] cnt;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             rsp_read_q;
    logic [XLEN-1:0]  ram_rdata;
    logic             commit_c;
    logic             err_c;
    logic             ram_en_c;

    // The commit cycle is the last WAIT cycle; errors never touch the RAM, reset cancels the commit.
    assign commit_c = (state == WAIT) && (cnt == '0);
    assign err_c    = is_misaligned(req_q.addr[1:0]) || (|(req_q.addr >> (AW + 2)));
    assign ram_en_c = commit_c && !err_c && !reset;

    // Request/response sequencing with wait-state countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= '0;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_read_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        req_q       <= '{we: bus.req_we, addr: bus.req_addr,
                                         wdata: bus.req_wdata, be: bus.req_be};
                        cnt         <= CNT_W'(WAIT_CYCLES);
                        req_ready_q <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_c;
                        rsp_read_q  <= !err_c && !req_q.we;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_read_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    data_mem_responder_dmem_array #(
        .AW (AW)
    ) u_dmem_array (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (req_q.we),
        .be    (req_q.be),
        .index (req_q.addr[AW+1:2]),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    // Read data is only exposed for a successful read; the RAM read register is never cleared.
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_read_q ? ram_rdata : '0;

endmodule
